// File: rtl/vector_fu_arbiter.sv
// Two-port round-robin arbiter in front of a single vector function unit.
// Optional watchdog on the BUSY wait is enabled by defining VFU_ARB_WATCHDOG_EN.
module vector_fu_arbiter #(
  parameter int VECTOR_SIZE = 8,
  parameter int DATA_LEN    = 32,
  parameter int OP_WIDTH    = 1200,
  parameter int TIMEOUT     = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rdy_in,
  input  logic [1:0]                      req_valid,
  output logic [1:0]                      req_ready,
  input  logic [2*OP_WIDTH-1:0]           req_op,
  output logic                            vfu_execute,
  output logic [OP_WIDTH-1:0]             vfu_op,
  input  logic [1:0]                      vfu_status,
  input  logic [VECTOR_SIZE*DATA_LEN-1:0] vfu_result,
  input  logic                            vfu_is_mask,
  output logic [1:0]                      rsp_valid,
  input  logic [1:0]                      rsp_ready,
  output logic [VECTOR_SIZE*DATA_LEN-1:0] rsp_result,
  output logic                            rsp_is_mask,
  output logic                            rsp_err,
  output logic                            busy
);

  localparam int RES_W = VECTOR_SIZE * DATA_LEN;

  // VFU status encoding: 0 = NOP, 1 = WORKING, 2 = FINISHED
  localparam logic [1:0] VEC_ALU_NOP      = 2'd0;
  localparam logic [1:0] VEC_ALU_FINISHED = 2'd2;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("vector_fu_arbiter: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [OP_WIDTH-1:0] op_q, op_d;
  logic [RES_W-1:0]    res_q, res_d;
  logic                mask_q, mask_d;
  logic                grant_vld;
  logic                grant;

`ifdef VFU_ARB_WATCHDOG_EN
  localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);
  logic [7:0] wdog_q, wdog_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    res_d        = res_q;
    mask_d       = mask_q;
    req_ready    = 2'b00;
    vfu_execute  = 1'b0;
    rsp_valid    = 2'b00;
    grant_vld    = 1'b0;
    grant        = 1'b0;
`ifdef VFU_ARB_WATCHDOG_EN
    wdog_d       = wdog_q;
    err_d        = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        // A tie goes to the port that did not win last time.
        if (rdy_in && vfu_status == VEC_ALU_NOP) begin
          if (&req_valid) begin
            grant_vld = 1'b1;
            grant     = ~last_grant_q;
          end else if (req_valid[0]) begin
            grant_vld = 1'b1;
            grant     = 1'b0;
          end else if (req_valid[1]) begin
            grant_vld = 1'b1;
            grant     = 1'b1;
          end
        end
        if (grant_vld) begin
          req_ready[grant] = 1'b1;
          owner_d          = grant;
          last_grant_d     = grant;
          op_d             = grant ? req_op[2*OP_WIDTH-1 -: OP_WIDTH]
                                   : req_op[OP_WIDTH-1:0];
          state_d          = S_ISSUE;
        end
      end

      S_ISSUE: begin
        vfu_execute = rdy_in;
        if (rdy_in) begin
          state_d = S_BUSY;
`ifdef VFU_ARB_WATCHDOG_EN
          wdog_d  = 8'd0;
`endif
        end
      end

      S_BUSY: begin
        if (rdy_in) begin
          if (vfu_status == VEC_ALU_FINISHED) begin
            res_d   = vfu_result;
            mask_d  = vfu_is_mask;
            state_d = S_RESP;
`ifdef VFU_ARB_WATCHDOG_EN
            err_d   = 1'b0;
          end else if (wdog_q == TO_M1) begin
            res_d   = '0;
            mask_d  = 1'b0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            wdog_d  = wdog_q + 8'd1;
`endif
          end
        end
      end

      S_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rdy_in && rsp_ready[owner_q]) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= '0;
      res_q        <= '0;
      mask_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      res_q        <= res_d;
      mask_q       <= mask_d;
    end
  end

`ifdef VFU_ARB_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign vfu_op      = op_q;
  assign rsp_result  = res_q;
  assign rsp_is_mask = mask_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_vector_fu_arbiter.sv
// Scoreboard bench for vector_fu_arbiter with a behavioural VFU model.
// Watchdog expectations follow VFU_ARB_WATCHDOG_EN when it is defined for the build.
module tb_vector_fu_arbiter;

  localparam int VS = 4;
  localparam int DL = 8;
  localparam int OW = 16;
  localparam int TO = 64;
  localparam int RW = VS * DL;

  localparam logic [1:0] NOP      = 2'd0;
  localparam logic [1:0] WORKING  = 2'd1;
  localparam logic [1:0] FINISHED = 2'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy_in;
  logic [1:0]    req_valid, req_ready;
  logic [2*OW-1:0] req_op;
  logic          vfu_execute;
  logic [OW-1:0] vfu_op;
  logic [1:0]    vfu_status;
  logic [RW-1:0] vfu_result;
  logic          vfu_is_mask;
  logic [1:0]    rsp_valid, rsp_ready;
  logic [RW-1:0] rsp_result;
  logic          rsp_is_mask, rsp_err, busy;

  vector_fu_arbiter #(
    .VECTOR_SIZE(VS), .DATA_LEN(DL), .OP_WIDTH(OW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .vfu_execute(vfu_execute), .vfu_op(vfu_op),
    .vfu_status(vfu_status), .vfu_result(vfu_result), .vfu_is_mask(vfu_is_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_is_mask(rsp_is_mask), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          own;
    logic [RW-1:0] res;
    logic          msk;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  int   grant_q[$];
  int   n_acc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_err_mode = 1'b0;
  logic model_en = 1'b1;
  logic stuck = 1'b0;
  int   lat = 3;

  function automatic logic [RW-1:0] res_f(input logic [OW-1:0] op);
    return {VS{op[7:0] ^ op[15:8]}};
  endfunction

  function automatic logic mask_f(input logic [OW-1:0] op);
    return ^op;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_req_ready"},   32'(req_ready),   0);
    chk({pfx, "_vfu_execute"}, 32'(vfu_execute), 0);
    chk({pfx, "_vfu_op"},      32'(vfu_op),      0);
    chk({pfx, "_rsp_valid"},   32'(rsp_valid),   0);
    chk({pfx, "_rsp_result"},  rsp_result,       0);
    chk({pfx, "_rsp_is_mask"}, 32'(rsp_is_mask), 0);
    chk({pfx, "_rsp_err"},     32'(rsp_err),     0);
    chk({pfx, "_busy"},        32'(busy),        0);
  endtask

  task automatic wait_acc(input string tag, input int target, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (n_acc >= target) break;
    end
    chk(tag, 32'(n_acc >= target), 1);
  endtask

  task automatic wait_drain(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (sb_q.size() == 0 && !busy) break;
      @(negedge clk);
    end
    chk(tag, sb_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    sb_q.delete();
    grant_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // VFU model: WORKING after execute, FINISHED 'lat' cycles later, NOP once the response is up.
  initial begin : vfu_model
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (model_en) begin
        if (vfu_execute) begin
          vfu_status = WORKING;
          vfu_result = $urandom;
          cnt = lat;
        end else if (vfu_status == WORKING && !stuck) begin
          if (cnt <= 1) begin
            vfu_status  = FINISHED;
            vfu_result  = res_f(vfu_op);
            vfu_is_mask = mask_f(vfu_op);
          end else begin
            cnt--;
          end
        end else if (vfu_status == FINISHED && rsp_valid != 2'b00) begin
          vfu_status = NOP;
        end
      end
    end
  end

  // Monitor: pushes expectations at acceptance, pops at response handshake.
  initial begin : monitor
    exp_t          e;
    logic          g;
    logic [OW-1:0] op;
    forever begin
      @(negedge clk);
      #4;
      if (rst && rdy_in) begin
        if ((req_valid & req_ready) != 2'b00) begin
          g     = req_ready[1];
          op    = g ? req_op[2*OW-1 -: OW] : req_op[OW-1:0];
          e.own = g;
          e.err = exp_err_mode;
          e.res = exp_err_mode ? '0 : res_f(op);
          e.msk = exp_err_mode ? 1'b0 : mask_f(op);
          sb_q.push_back(e);
          grant_q.push_back(int'(g));
          n_acc++;
        end
        if (rsp_valid != 2'b00) begin
          chk("rsp_onehot", 32'($onehot(rsp_valid)), 1);
          g = rsp_valid[1];
          if (rsp_ready[g]) begin
            chk("sb_nonempty", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
              e = sb_q.pop_front();
              chk("rsp_owner",   32'(g),           32'(e.own));
              chk("rsp_result",  rsp_result,       e.res);
              chk("rsp_is_mask", 32'(rsp_is_mask), 32'(e.msk));
              chk("rsp_err",     32'(rsp_err),     32'(e.err));
            end
          end
        end
      end
    end
  end

  initial begin : main
    int            base;
    int            first;
    int            viol;
    logic [RW-1:0] held;
    logic [OW-1:0] op1;

    rst = 1'b0; rdy_in = 1'b1; req_valid = 2'b00; req_op = '0; rsp_ready = 2'b11;
    vfu_status = NOP; vfu_result = '0; vfu_is_mask = 1'b0;
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single request timing: ready c0, execute c1, response c5 with 3-cycle VFU.
    @(negedge clk);
    req_valid = 2'b01; req_op[OW-1:0] = 16'hA5C3;
    #1 chk("t1_req_ready_c0", 32'(req_ready), 32'(2'b01));
    @(negedge clk);
    req_valid = 2'b00;
    #1 chk("t1_exec_c1", 32'(vfu_execute), 1);
    chk("t1_vfu_op", 32'(vfu_op), 32'h0000A5C3);
    chk("t1_busy_c1", 32'(busy), 1);
    @(negedge clk);
    #1 chk("t1_exec_c2", 32'(vfu_execute), 0);
    @(negedge clk);
    @(negedge clk);
    #1 chk("t1_rsp_c4", 32'(rsp_valid), 0);
    @(negedge clk);
    #1 chk("t1_rsp_c5", 32'(rsp_valid), 32'(2'b01));
    wait_drain("t1_drain", 20);

    // Round-robin with both ports continuously valid.
    do_reset();
    base = n_acc;
    @(negedge clk);
    req_valid = 2'b11;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      req_op = $urandom;
      if (n_acc >= base + 4) break;
    end
    req_valid = 2'b00;
    chk("t2_accepts", 32'(n_acc - base), 4);
    wait_drain("t2_drain", 40);
    chk("t2_grant_count", grant_q.size(), 4);
    for (int i = 0; i < 4 && i < grant_q.size(); i++)
      chk($sformatf("t2_grant%0d", i), 32'(grant_q[i]), 32'(i % 2));

    // Response back-pressure: owner port 1 stalls, port 0 waits, non-owner ready ignored.
    base = n_acc;
    @(negedge clk);
    rsp_ready = 2'b01; req_valid = 2'b10;
    op1 = 16'h3C7E;
    req_op = {op1, 16'h1111};
    wait_acc("t3_acc1", base + 1, 20);
    req_valid = 2'b01;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid != 2'b00) break;
    end
    chk("t3_rsp_seen", 32'(rsp_valid), 32'(2'b10));
    held = rsp_result;
    chk("t3_result", held, res_f(op1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("t3_hold_valid",  32'(rsp_valid), 32'(2'b10));
      chk("t3_hold_result", rsp_result,     held);
      chk("t3_hold_busy",   32'(busy),      1);
      chk("t3_no_grant",    32'(req_ready), 0);
    end
    rsp_ready = 2'b11;
    wait_acc("t3_acc2", base + 2, 20);
    req_valid = 2'b00;
    wait_drain("t3_drain", 30);

    // rdy_in low for 5 cycles while in ISSUE.
    @(negedge clk);
    req_valid = 2'b01; req_op = {16'h0000, 16'h5AF0};
    @(posedge clk);
    #1 rdy_in = 1'b0; req_valid = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 chk("t4_frozen_exec", 32'(vfu_execute), 0);
      chk("t4_frozen_busy", 32'(busy), 1);
    end
    @(posedge clk);
    #1 rdy_in = 1'b1;
    @(negedge clk);
    #1 chk("t4_exec_after", 32'(vfu_execute), 1);
    @(negedge clk);
    #1 chk("t4_exec_once", 32'(vfu_execute), 0);
    wait_drain("t4_drain", 30);

    // Reset while BUSY: outputs clear, first grant waits for NOP, tie goes to port 0.
    base = n_acc;
    stuck = 1'b1;
    @(negedge clk);
    req_valid = 2'b01; req_op = {16'h0000, 16'h0F0F};
    wait_acc("t5_acc", base + 1, 20);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    #1 chk("t5_busy_before", 32'(busy), 1);
    rst = 1'b0;
    #1;
    chk_zero("t5_rst");
    sb_q.delete();
    model_en = 1'b0; stuck = 1'b0; vfu_status = WORKING;
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b11; req_op = {16'hBEEF, 16'hC0DE};
    #1 chk("t5_wait_nop_a", 32'(req_ready), 0);
    @(negedge clk);
    #1 chk("t5_wait_nop_b", 32'(req_ready), 0);
    vfu_status = NOP;
    #1 chk("t5_tie_port0", 32'(req_ready), 32'(2'b01));
    model_en = 1'b1;
    base = n_acc;
    wait_acc("t5_acc_both", base + 2, 40);
    req_valid = 2'b00;
    wait_drain("t5_drain", 30);

    // Stuck VFU: watchdog response or indefinite wait.
    stuck = 1'b1;
`ifdef VFU_ARB_WATCHDOG_EN
    exp_err_mode = 1'b1;
`endif
    first = 0; viol = 0;
    @(negedge clk);
    req_valid = 2'b10; req_op = {16'h7777, 16'h0000};
    #1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 2'b00;
      #1;
      if (rsp_valid != 2'b00 && first == 0) begin
        first = c;
        chk("t6_err_flag", 32'(rsp_err), 1);
      end
      if (rsp_valid != 2'b00 || !busy) viol++;
`ifdef VFU_ARB_WATCHDOG_EN
      if (first != 0) break;
`endif
    end
`ifdef VFU_ARB_WATCHDOG_EN
    chk("t6_wdog_cycle", 32'(first), 66);
    wait_drain("t6_drain", 10);
`else
    chk("t6_no_rsp", 32'(viol), 0);
    chk("t6_busy_held", 32'(busy), 1);
`endif
    exp_err_mode = 1'b0;
    model_en = 1'b0; stuck = 1'b0; vfu_status = NOP;
    do_reset();
    model_en = 1'b1;
    chk("t6_after_reset_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
